cpu_health_monitor: RTL and testbench

//  Watchdog producing CPUA_fail/CPUB_fail for the shared-memory/switch-board block. Snoops both CPU

---
 rtl/cpu_health_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_cpu_health_monitor.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_health_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cpu_health_monitor
// Purpose  : Heartbeat watchdog for two CPUs sharing the memory/switch board.
//            Snoops both CPU write buses for heartbeat writes. One FSM per CPU
//            (INIT / ALIVE / SUSPECT / FAILED) declares a CPU failed after it
//            misses its first-heartbeat window or too many consecutive
//            heartbeat windows. FAILED is sticky. A healthy CPU can clear
//            its peer's failure by writing a keyed command word.
// Ports    : clk, rst                       - clock, synchronous active-high reset
//            A_addr/A_write_data/A_we       - CPU A write bus (snooped)
//            B_addr/B_write_data/B_we       - CPU B write bus (snooped)
//            CPUA_fail/CPUB_fail            - sticky failure flags (registered)
//            A_state/B_state                - FSM state: 00 INIT, 01 ALIVE,
//                                             10 SUSPECT, 11 FAILED
// Options  : HB_SEQ_CHECK_EN - when defined, heartbeat data is a sequence
//            number that must increment by one per heartbeat. A wrong value
//            fails the CPU immediately.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_health_monitor #(
    parameter logic [23:0] TIMEOUT       = 24'd50000,
    parameter logic [23:0] INIT_TIMEOUT  = 24'd500000,
    parameter int unsigned SUSPECT_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] A_addr,
    input  logic [31:0] A_write_data,
    input  logic        A_we,
    input  logic [21:0] B_addr,
    input  logic [31:0] B_write_data,
    input  logic        B_we,
    output logic        CPUA_fail,
    output logic        CPUB_fail,
    output logic [1:0]  A_state,
    output logic [1:0]  B_state
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [21:0] c_HB_ADDR_A  = 22'h2401;
    localparam logic [21:0] c_HB_ADDR_B  = 22'h2402;
    localparam logic [21:0] c_CLR_ADDR   = 22'h2403;
    localparam logic [23:0] c_CLR_KEY    = 24'hC1EA00;
    localparam logic [4:0]  c_LIMIT      = 5'(SUSPECT_LIMIT);
    localparam logic [23:0] c_INIT_LAST  = INIT_TIMEOUT - 24'd1;
    localparam logic [23:0] c_WIN_LAST   = TIMEOUT - 24'd1;

    typedef enum logic [1:0] {
        ST_INIT    = 2'b00,
        ST_ALIVE   = 2'b01,
        ST_SUSPECT = 2'b10,
        ST_FAILED  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Per-CPU state. Index 0 is CPU A, index 1 is CPU B.
    // ------------------------------------------------------------------
    state_t      r_state [2];
    logic [23:0] r_cnt   [2];
    logic [3:0]  r_miss  [2];
    logic [1:0]  r_fail;

    logic [1:0]  w_hb;        // heartbeat write seen on the CPU's own bus
    logic [1:0]  w_cmd;       // keyed clear command issued by this CPU
    logic [1:0]  w_clr;       // accepted clear targeting this CPU
    logic [1:0]  w_tc_init;   // last cycle of the first-heartbeat window
    logic [1:0]  w_tc_win;    // last cycle of a heartbeat window
    logic [1:0]  w_seq_ok;    // heartbeat data acceptable

`ifdef HB_SEQ_CHECK_EN
    logic [31:0] r_exp  [2];
    logic [31:0] w_data [2];
`else
    // Low command bits not used as target selectors, and heartbeat data,
    // carry no meaning when sequence checking is off.
    logic w_unused;
    assign w_unused = ^{A_write_data[7:2], A_write_data[0],
                        B_write_data[7:2], B_write_data[1]};
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    always_comb begin
        w_hb[0]  = A_we && (A_addr == c_HB_ADDR_A);
        w_hb[1]  = B_we && (B_addr == c_HB_ADDR_B);
        w_cmd[0] = A_we && (A_addr == c_CLR_ADDR) && (A_write_data[31:8] == c_CLR_KEY);
        w_cmd[1] = B_we && (B_addr == c_CLR_ADDR) && (B_write_data[31:8] == c_CLR_KEY);

        // A clear is honoured only when the issuer is itself healthy (not
        // FAILED) and only for the peer; the self-target bit is ignored.
        // It has an effect only on a FAILED target, so two simultaneous
        // clears between healthy CPUs do nothing.
        w_clr[0] = w_cmd[1] && B_write_data[0]
                   && (r_state[1] != ST_FAILED) && (r_state[0] == ST_FAILED);
        w_clr[1] = w_cmd[0] && A_write_data[1]
                   && (r_state[0] != ST_FAILED) && (r_state[1] == ST_FAILED);

        for (int i = 0; i < 2; i++) begin
            w_tc_init[i] = (r_cnt[i] == c_INIT_LAST);
            w_tc_win[i]  = (r_cnt[i] == c_WIN_LAST);
        end

`ifdef HB_SEQ_CHECK_EN
        w_data[0] = A_write_data;
        w_data[1] = B_write_data;
        for (int i = 0; i < 2; i++) begin
            w_seq_ok[i] = (w_data[i] == r_exp[i]);
        end
`else
        w_seq_ok = 2'b11;
`endif
    end

    // ------------------------------------------------------------------
    // Per-CPU FSM, window counter and miss counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= ST_INIT;
                r_cnt[i]   <= '0;
                r_miss[i]  <= '0;
                r_fail[i]  <= 1'b0;
`ifdef HB_SEQ_CHECK_EN
                r_exp[i]   <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                // Failure flag lags the state register by one cycle.
                r_fail[i] <= (r_state[i] == ST_FAILED);

                unique case (r_state[i])
                    ST_INIT: begin
                        if (w_hb[i]) begin
                            // First heartbeat is never checked; it seeds
                            // the sequence.
                            r_state[i] <= ST_ALIVE;
                            r_cnt[i]   <= '0;
`ifdef HB_SEQ_CHECK_EN
                            r_exp[i]   <= w_data[i] + 32'd1;
`endif
                        end else if (w_tc_init[i]) begin
                            r_state[i] <= ST_FAILED;
                            r_cnt[i]   <= '0;
                        end else begin
                            r_cnt[i]   <= r_cnt[i] + 24'd1;
                        end
                    end

                    ST_ALIVE: begin
                        if (w_hb[i]) begin
                            r_cnt[i] <= '0;
                            if (w_seq_ok[i]) begin
`ifdef HB_SEQ_CHECK_EN
                                r_exp[i] <= r_exp[i] + 32'd1;
`endif
                            end else begin
                                r_state[i] <= ST_FAILED;
                            end
                        end else if (w_tc_win[i]) begin
                            r_cnt[i]  <= '0;
                            r_miss[i] <= 4'd1;
                            r_state[i] <= (c_LIMIT <= 5'd1) ? ST_FAILED : ST_SUSPECT;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 24'd1;
                        end
                    end

                    ST_SUSPECT: begin
                        if (w_hb[i]) begin
                            r_cnt[i] <= '0;
                            if (w_seq_ok[i]) begin
                                r_state[i] <= ST_ALIVE;
                                r_miss[i]  <= '0;
`ifdef HB_SEQ_CHECK_EN
                                r_exp[i]   <= r_exp[i] + 32'd1;
`endif
                            end else begin
                                r_state[i] <= ST_FAILED;
                            end
                        end else if (w_tc_win[i]) begin
                            // Each missed window restarts the counter so the
                            // next window is measured from here.
                            r_cnt[i]  <= '0;
                            r_miss[i] <= r_miss[i] + 4'd1;
                            if (({1'b0, r_miss[i]} + 5'd1) >= c_LIMIT) begin
                                r_state[i] <= ST_FAILED;
                            end
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 24'd1;
                        end
                    end

                    ST_FAILED: begin
                        // Heartbeats are ignored and the counter is frozen;
                        // only a peer clear (or rst) leaves this state.
                        if (w_clr[i]) begin
                            r_state[i] <= ST_INIT;
                            r_cnt[i]   <= '0;
                            r_miss[i]  <= '0;
`ifdef HB_SEQ_CHECK_EN
                            r_exp[i]   <= '0;
`endif
                        end
                    end

                    default: begin
                        r_state[i] <= ST_FAILED;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign A_state   = r_state[0];
    assign B_state   = r_state[1];
    assign CPUA_fail = r_fail[0];
    assign CPUB_fail = r_fail[1];

endmodule
`default_nettype wire

// File: tb/tb_cpu_health_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_health_monitor
// Purpose  : Self-checking bench for cpu_health_monitor with TIMEOUT=8,
//            INIT_TIMEOUT=20, SUSPECT_LIMIT=2. A window-based reference
//            model tracks each CPU; directed scenarios add fixed-value
//            checks at the boundaries, and a random phase runs the model
//            against mixed bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_health_monitor;

    localparam int TO_T   = 8;
    localparam int INIT_T = 20;
    localparam int LIM    = 2;
`ifdef HB_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    localparam logic [21:0] HB_A     = 22'h2401;
    localparam logic [21:0] HB_B     = 22'h2402;
    localparam logic [21:0] CLR_ADDR = 22'h2403;
    localparam logic [31:0] CLR_A    = 32'hC1EA0001;
    localparam logic [31:0] CLR_B    = 32'hC1EA0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] A_addr = '0;
    logic [31:0] A_write_data = '0;
    logic        A_we = 1'b0;
    logic [21:0] B_addr = '0;
    logic [31:0] B_write_data = '0;
    logic        B_we = 1'b0;
    logic        CPUA_fail, CPUB_fail;
    logic [1:0]  A_state, B_state;
    logic [5:0]  w_obs;

    always #5 clk = ~clk;

    cpu_health_monitor #(
        .TIMEOUT      (24'(TO_T)),
        .INIT_TIMEOUT (24'(INIT_T)),
        .SUSPECT_LIMIT(LIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .A_addr      (A_addr),
        .A_write_data(A_write_data),
        .A_we        (A_we),
        .B_addr      (B_addr),
        .B_write_data(B_write_data),
        .B_we        (B_we),
        .CPUA_fail   (CPUA_fail),
        .CPUB_fail   (CPUB_fail),
        .A_state     (A_state),
        .B_state     (B_state)
    );

    assign w_obs = {A_state, B_state, CPUA_fail, CPUB_fail};

    int n_checks = 0;
    int n_pass   = 0;

    // ------------------------------------------------------------------
    // Reference model: mode 0 INIT, 1 ALIVE, 2 SUSPECT, 3 FAILED;
    // m_cnt = cycles already spent in the current window.
    // ------------------------------------------------------------------
    int          m_st   [2];
    int          m_cnt  [2];
    int          m_miss [2];
    logic [31:0] m_exp  [2];
    bit          m_fail [2];
    logic [31:0] nseq   [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_miss[i] = 0; m_exp[i] = '0; m_fail[i] = 1'b0;
            nseq[i] = $urandom;
        end
    endfunction

    function automatic logic [5:0] mvec();
        return {2'(m_st[0]), 2'(m_st[1]), m_fail[0], m_fail[1]};
    endfunction

    function automatic void model_step(input logic aw, input logic [21:0] aa, input logic [31:0] ad,
                                       input logic bw, input logic [21:0] ba, input logic [31:0] bd);
        logic        we   [2];
        logic [21:0] addr [2];
        logic [31:0] data [2];
        int          prev [2];
        we[0] = aw; we[1] = bw; addr[0] = aa; addr[1] = ba; data[0] = ad; data[1] = bd;
        prev[0] = m_st[0]; prev[1] = m_st[1];
        for (int i = 0; i < 2; i++) begin
            int p;
            bit hb;
            bit clr;
            int win;
            p   = 1 - i;
            m_fail[i] = (prev[i] == 3);
            hb  = we[i] && (addr[i] == ((i == 0) ? HB_A : HB_B));
            clr = we[p] && (addr[p] == CLR_ADDR) && (data[p][31:8] == 24'hC1EA00)
                  && data[p][i] && (prev[p] != 3);
            win = (prev[i] == 0) ? INIT_T : TO_T;
            if (prev[i] == 3) begin
                if (clr) begin
                    m_st[i] = 0; m_cnt[i] = 0; m_miss[i] = 0; m_exp[i] = '0;
                end
            end else if (hb) begin
                if (prev[i] == 0) begin
                    m_st[i] = 1; m_exp[i] = data[i] + 32'd1;
                end else if (SEQ && (data[i] != m_exp[i])) begin
                    m_st[i] = 3;
                end else begin
                    m_st[i] = 1; m_miss[i] = 0; m_exp[i] = m_exp[i] + 32'd1;
                end
                m_cnt[i] = 0;
            end else if (m_cnt[i] + 1 == win) begin
                m_cnt[i] = 0;
                if (prev[i] == 0) m_st[i] = 3;
                else begin
                    m_miss[i] = m_miss[i] + 1;
                    m_st[i]   = (m_miss[i] >= LIM) ? 3 : 2;
                end
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus primitives
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst = 1'b1; A_we = 1'b0; B_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic tick(input logic aw, input logic [21:0] aa, input logic [31:0] ad,
                        input logic bw, input logic [21:0] ba, input logic [31:0] bd);
        A_we = aw; A_addr = aa; A_write_data = ad;
        B_we = bw; B_addr = ba; B_write_data = bd;
        @(posedge clk);
        #1;
        model_step(aw, aa, ad, bw, ba, bd);
        A_we = 1'b0; B_we = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 22'd0, 32'd0, 1'b0, 22'd0, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (w_obs !== 6'b000000) $display("FAIL reset_state got=%b exp=%b", w_obs, 6'b000000);
        else n_pass++;
    endtask

    task automatic test_init_timeout();
        logic [2:0] exp3;
        do_reset();
        for (int k = 1; k <= 22; k++) begin
            idle();
            n_checks++;
            if (w_obs !== mvec()) $display("FAIL init_model k=%0d got=%b exp=%b", k, w_obs, mvec());
            else n_pass++;
            if (k >= 19 && k <= 21) begin
                exp3 = (k == 19) ? 3'b000 : (k == 20) ? 3'b110 : 3'b111;
                n_checks++;
                if ({A_state, CPUA_fail} !== exp3)
                    $display("FAIL init_timeout k=%0d got=%b exp=%b", k, {A_state, CPUA_fail}, exp3);
                else n_pass++;
            end
        end
        // Both FAILED: clears from either side must be ignored.
        tick(1'b1, CLR_ADDR, CLR_B, 1'b1, CLR_ADDR, CLR_A);
        n_checks++;
        if (w_obs !== 6'b111111) $display("FAIL both_failed_clear got=%b exp=%b", w_obs, 6'b111111);
        else n_pass++;
        // rst recovers from FAILED.
        do_reset();
        n_checks++;
        if (w_obs !== 6'b000000) $display("FAIL reset_from_failed got=%b exp=%b", w_obs, 6'b000000);
        else n_pass++;
    endtask

    task automatic test_alive_periodic();
        logic aw, bw;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            aw = (k % 6 == 0);
            bw = (k % 6 == 3);
            tick(aw, HB_A, nseq[0], bw, HB_B, nseq[1]);
            if (aw) nseq[0]++;
            if (bw) nseq[1]++;
            n_checks++;
            if (w_obs !== mvec()) $display("FAIL alive_model k=%0d got=%b exp=%b", k, w_obs, mvec());
            else n_pass++;
            n_checks++;
            if ({A_state, CPUA_fail} !== 3'b010)
                $display("FAIL alive_periodic k=%0d got=%b exp=%b", k, {A_state, CPUA_fail}, 3'b010);
            else n_pass++;
        end
    endtask

    task automatic test_suspect_fail();
        logic       bw;
        logic [1:0] exps;
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            bw = (k % 5 == 0);
            tick(k == 0, HB_A, nseq[0], bw, HB_B, nseq[1]);
            if (k == 0) nseq[0]++;
            if (bw) nseq[1]++;
            n_checks++;
            if (w_obs !== mvec()) $display("FAIL suspect_model k=%0d got=%b exp=%b", k, w_obs, mvec());
            else n_pass++;
            if (k == 7 || k == 8 || k == 15 || k == 16) begin
                exps = (k == 7) ? 2'b01 : (k == 16) ? 2'b11 : 2'b10;
                n_checks++;
                if (A_state !== exps) $display("FAIL suspect_timing k=%0d got=%b exp=%b", k, A_state, exps);
                else n_pass++;
            end
        end
        // Healthy B clears A.
        tick(1'b0, 22'd0, 32'd0, 1'b1, CLR_ADDR, CLR_A);
        n_checks++;
        if (A_state !== 2'b00) $display("FAIL b_clears_a got=%b exp=%b", A_state, 2'b00);
        else n_pass++;
        idle();
        n_checks++;
        if ({A_state, CPUA_fail} !== 3'b000)
            $display("FAIL b_clears_a_flag got=%b exp=%b", {A_state, CPUA_fail}, 3'b000);
        else n_pass++;
        // Recovery from SUSPECT: hb 12 cycles after the previous one.
        for (int k = 0; k <= 12; k++) begin
            bw = (k % 5 == 0);
            tick(k == 0 || k == 12, HB_A, nseq[0], bw, HB_B, nseq[1]);
            if (k == 0 || k == 12) nseq[0]++;
            if (bw) nseq[1]++;
            n_checks++;
            if (w_obs !== mvec()) $display("FAIL recover_model k=%0d got=%b exp=%b", k, w_obs, mvec());
            else n_pass++;
            if (k == 11 || k == 12) begin
                exps = (k == 11) ? 2'b10 : 2'b01;
                n_checks++;
                if (A_state !== exps) $display("FAIL suspect_recover k=%0d got=%b exp=%b", k, A_state, exps);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clear();
        logic aw;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            aw = (k % 4 == 0);
            tick(aw, HB_A, nseq[0], 1'b0, 22'd0, 32'd0);
            if (aw) nseq[0]++;
            n_checks++;
            if (w_obs !== mvec()) $display("FAIL clear_model k=%0d got=%b exp=%b", k, w_obs, mvec());
            else n_pass++;
        end
        n_checks++;
        if ({B_state, CPUB_fail} !== 3'b111) $display("FAIL b_failed got=%b exp=%b", {B_state, CPUB_fail}, 3'b111);
        else n_pass++;
        // FAILED B tries to clear itself: no effect.
        tick(1'b1, HB_A, nseq[0], 1'b1, CLR_ADDR, CLR_B);
        nseq[0]++;
        n_checks++;
        if ({B_state, CPUB_fail} !== 3'b111) $display("FAIL b_self_clear got=%b exp=%b", {B_state, CPUB_fail}, 3'b111);
        else n_pass++;
        // Healthy A clears B.
        tick(1'b1, CLR_ADDR, CLR_B, 1'b0, 22'd0, 32'd0);
        n_checks++;
        if (B_state !== 2'b00) $display("FAIL a_clears_b got=%b exp=%b", B_state, 2'b00);
        else n_pass++;
        idle();
        n_checks++;
        if ({B_state, CPUB_fail} !== 3'b000) $display("FAIL a_clears_b_flag got=%b exp=%b", {B_state, CPUB_fail}, 3'b000);
        else n_pass++;
        n_checks++;
        if (w_obs !== mvec()) $display("FAIL clear_end_model got=%b exp=%b", w_obs, mvec());
        else n_pass++;
    endtask

    task automatic test_hb_tc_same();
        do_reset();
        tick(1'b1, HB_A, nseq[0], 1'b0, 22'd0, 32'd0);
        nseq[0]++;
        for (int k = 1; k <= 7; k++) idle();
        // Heartbeat lands on the terminal-count cycle.
        tick(1'b1, HB_A, nseq[0], 1'b0, 22'd0, 32'd0);
        nseq[0]++;
        n_checks++;
        if (A_state !== 2'b01) $display("FAIL hb_at_tc got=%b exp=%b", A_state, 2'b01);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            idle();
            n_checks++;
            if (w_obs !== mvec()) $display("FAIL tc_model k=%0d got=%b exp=%b", k, w_obs, mvec());
            else n_pass++;
        end
        n_checks++;
        if (A_state !== 2'b10) $display("FAIL window_after_tc_hb got=%b exp=%b", A_state, 2'b10);
        else n_pass++;
        tick(1'b1, HB_A, nseq[0], 1'b0, 22'd0, 32'd0);
        nseq[0]++;
        for (int k = 1; k <= 4; k++) idle();
        n_checks++;
        if (B_state !== 2'b11) $display("FAIL b_init_fail got=%b exp=%b", B_state, 2'b11);
        else n_pass++;
        // Clear and B heartbeat in the same cycle: clear wins.
        tick(1'b1, CLR_ADDR, CLR_B, 1'b1, HB_B, nseq[1]);
        nseq[1]++;
        n_checks++;
        if (B_state !== 2'b00) $display("FAIL clear_vs_hb got=%b exp=%b", B_state, 2'b00);
        else n_pass++;
        tick(1'b0, 22'd0, 32'd0, 1'b1, HB_B, nseq[1]);
        nseq[1]++;
        n_checks++;
        if (w_obs !== mvec()) $display("FAIL clear_vs_hb_model got=%b exp=%b", w_obs, mvec());
        else n_pass++;
    endtask

    task automatic test_random();
        logic        w [2];
        logic [21:0] a [2];
        logic [31:0] d [2];
        int          r;
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    r    = int'($urandom_range(0, 99));
                    w[i] = 1'b1;
                    d[i] = $urandom;
                    a[i] = 22'($urandom);
                    if (r < 12) begin
                        a[i] = (i == 0) ? HB_A : HB_B;
                        if (SEQ && ($urandom_range(0, 9) != 0)) d[i] = m_exp[i];
                    end else if (r < 16) begin
                        a[i] = CLR_ADDR;
                        d[i] = {24'hC1EA00, 6'($urandom), 2'($urandom)};
                    end else if (r < 18) begin
                        a[i] = (i == 0) ? HB_B : HB_A;
                    end else if (r < 20) begin
                        a[i] = CLR_ADDR;
                    end else begin
                        w[i] = 1'b0;
                    end
                end
                tick(w[0], a[0], d[0], w[1], a[1], d[1]);
            end
            n_checks++;
            if (w_obs !== mvec()) $display("FAIL random_model k=%0d got=%b exp=%b", k, w_obs, mvec());
            else n_pass++;
        end
    endtask

`ifdef HB_SEQ_CHECK_EN
    task automatic test_seq();
        do_reset();
        tick(1'b1, HB_A, 32'd5, 1'b0, 22'd0, 32'd0);
        tick(1'b1, HB_A, 32'd6, 1'b0, 22'd0, 32'd0);
        tick(1'b1, HB_A, 32'd7, 1'b0, 22'd0, 32'd0);
        n_checks++;
        if (A_state !== 2'b01) $display("FAIL seq_in_order got=%b exp=%b", A_state, 2'b01);
        else n_pass++;
        tick(1'b1, HB_A, 32'd9, 1'b0, 22'd0, 32'd0);
        n_checks++;
        if (A_state !== 2'b11) $display("FAIL seq_skip_state got=%b exp=%b", A_state, 2'b11);
        else n_pass++;
        idle();
        n_checks++;
        if (CPUA_fail !== 1'b1) $display("FAIL seq_skip_flag got=%b exp=%b", CPUA_fail, 1'b1);
        else n_pass++;
        do_reset();
        tick(1'b1, HB_A, 32'hFFFFFFFE, 1'b0, 22'd0, 32'd0);
        tick(1'b1, HB_A, 32'hFFFFFFFF, 1'b0, 22'd0, 32'd0);
        tick(1'b1, HB_A, 32'h00000000, 1'b0, 22'd0, 32'd0);
        n_checks++;
        if ({A_state, CPUA_fail} !== 3'b010) $display("FAIL seq_wrap got=%b exp=%b", {A_state, CPUA_fail}, 3'b010);
        else n_pass++;
        n_checks++;
        if (w_obs !== mvec()) $display("FAIL seq_model got=%b exp=%b", w_obs, mvec());
        else n_pass++;
    endtask
`endif

    // ------------------------------------------------------------------
    // Sequencer and run-time bound
    // ------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        model_reset();
        test_reset();
        test_init_timeout();
        test_alive_periodic();
        test_suspect_fail();
        test_clear();
        test_hb_tc_same();
`ifdef HB_SEQ_CHECK_EN
        test_seq();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
